// File: rtl/sensor_responder.sv
// rtl/sensor_responder.sv - remote-node UART request/response engine
// Answers read commands with data and checksum bytes; an alarm is signalled by a deliberate checksum mismatch.
module sensor_responder #(
    parameter logic [7:0]  CMD_READ      = 8'h01,
    parameter logic [7:0]  CMD_ACK_ALARM = 8'h02,
    parameter logic [7:0]  KEY           = 8'h37,
    parameter logic [7:0]  ALARM_CODE    = 8'h00,
    parameter logic [7:0]  ALARM_FILL    = 8'hFF,
    parameter int unsigned TX_GUARD      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rdy,
    input  logic [7:0]  rxdata,
    input  logic        tx_busy,
    input  logic        sensor_valid,
    input  logic [7:0]  sensor_data,
    input  logic        alarm_in,
    output logic        rdy_clr,
    output logic        wr_en,
    output logic [7:0]  txdata,
    output logic        busy,
    output logic        alarm_pending,
    output logic [15:0] req_count,
    output logic [7:0]  err_count
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DECODE     = 3'd1,
        SEND_DATA  = 3'd2,
        GUARD_DATA = 3'd3,
        SEND_CHK   = 3'd4,
        GUARD_CHK  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  sample_q, sample_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  chk_q, chk_d;
    logic [3:0]  guard_q, guard_d;
    logic        rdy_clr_q, rdy_clr_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  txdata_q, txdata_d;
    logic        busy_q, busy_d;
    logic        alarm_q, alarm_d;
    logic [15:0] req_q, req_d;
    logic [7:0]  err_q, err_d;

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        sample_d  = sensor_valid ? sensor_data : sample_q;
        data_d    = data_q;
        chk_d     = chk_q;
        guard_d   = guard_q;
        rdy_clr_d = 1'b0;
        wr_en_d   = 1'b0;
        txdata_d  = txdata_q;
        alarm_d   = alarm_q;
        req_d     = req_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (rdy) begin
                    cmd_d     = rxdata;
                    rdy_clr_d = 1'b1;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                if (cmd_q == CMD_READ) begin
                    // Reply bytes are frozen here so later samples cannot tear a response.
                    if (alarm_q) begin
                        data_d = ALARM_FILL;
                        chk_d  = ALARM_CODE ^ KEY;
                    end else begin
                        data_d = sample_q;
                        chk_d  = sample_q ^ KEY;
                    end
                    state_d = SEND_DATA;
                end else if (cmd_q == CMD_ACK_ALARM) begin
                    alarm_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    state_d = IDLE;
                end
            end
            SEND_DATA: begin
                if (!tx_busy) begin
                    wr_en_d  = 1'b1;
                    txdata_d = data_q;
                    guard_d  = 4'(TX_GUARD);
                    state_d  = GUARD_DATA;
                end
            end
            GUARD_DATA: begin
                // tx_busy lags wr_en, so it is ignored until the guard expires.
                if (guard_q != 4'd0) guard_d = guard_q - 4'd1;
                else if (!tx_busy)   state_d = SEND_CHK;
            end
            SEND_CHK: begin
                wr_en_d  = 1'b1;
                txdata_d = chk_q;
                guard_d  = 4'(TX_GUARD);
                state_d  = GUARD_CHK;
            end
            GUARD_CHK: begin
                if (guard_q != 4'd0) begin
                    guard_d = guard_q - 4'd1;
                end else if (!tx_busy) begin
                    req_d   = req_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (alarm_in) alarm_d = 1'b1;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cmd_q     <= 8'd0;
            sample_q  <= 8'd0;
            data_q    <= 8'd0;
            chk_q     <= 8'd0;
            guard_q   <= 4'd0;
            rdy_clr_q <= 1'b0;
            wr_en_q   <= 1'b0;
            txdata_q  <= 8'd0;
            busy_q    <= 1'b0;
            alarm_q   <= 1'b0;
            req_q     <= 16'd0;
            err_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            sample_q  <= sample_d;
            data_q    <= data_d;
            chk_q     <= chk_d;
            guard_q   <= guard_d;
            rdy_clr_q <= rdy_clr_d;
            wr_en_q   <= wr_en_d;
            txdata_q  <= txdata_d;
            busy_q    <= busy_d;
            alarm_q   <= alarm_d;
            req_q     <= req_d;
            err_q     <= err_d;
        end
    end

    assign rdy_clr       = rdy_clr_q;
    assign wr_en         = wr_en_q;
    assign txdata        = txdata_q;
    assign busy          = busy_q;
    assign alarm_pending = alarm_q;
    assign req_count     = req_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_sensor_responder.sv
// tb/tb_sensor_responder.sv - self-checking bench for sensor_responder
module tb_sensor_responder;

    logic        clk = 1'b0;
    logic        reset, rdy, tx_busy, sensor_valid, alarm_in;
    logic [7:0]  rxdata, sensor_data;
    logic        rdy_clr, wr_en, busy, alarm_pending;
    logic [7:0]  txdata, err_count;
    logic [15:0] req_count;

    sensor_responder dut (
        .clk(clk), .reset(reset), .rdy(rdy), .rxdata(rxdata), .tx_busy(tx_busy),
        .sensor_valid(sensor_valid), .sensor_data(sensor_data), .alarm_in(alarm_in),
        .rdy_clr(rdy_clr), .wr_en(wr_en), .txdata(txdata), .busy(busy),
        .alarm_pending(alarm_pending), .req_count(req_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus monitor: transmitted bytes, their cycle stamps, and rdy_clr pulses.
    logic [7:0] txq[$];
    int         wr_cyc[$];
    int         cyc = 0;
    int         clr_cnt = 0;
    int         clr_cyc = 0;
    logic       prev_wr = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (wr_en) begin
                txq.push_back(txdata);
                wr_cyc.push_back(cyc);
                check("wr_en_not_back_to_back", {31'd0, prev_wr}, 32'd0);
            end
            if (rdy_clr) begin
                clr_cnt++;
                clr_cyc = cyc;
            end
        end
        prev_wr = wr_en;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_sample(input logic [7:0] v);
        sensor_valid = 1'b1;
        sensor_data  = v;
        tick();
        sensor_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] c);
        bit ok;
        ok     = 1'b0;
        rdy    = 1'b1;
        rxdata = c;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rdy_clr) begin
                ok = 1'b1;
                break;
            end
        end
        rdy = 1'b0;
        if (!ok) check("rdy_clr_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        int         mode;   // 0 none, 1 alarm pulse before request, 2 alarm held during request
        logic [7:0] sensor;
        logic [7:0] cmd;
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        logic       ap;
        logic [15:0] req;
        logic [7:0] err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 8'h5A, 8'h01, 2, 8'h5A, 8'h6D, 1'b0, 16'd1, 8'd0};
        vecs[1] = '{1, 8'h5A, 8'h01, 2, 8'hFF, 8'h37, 1'b1, 16'd2, 8'd0};
        vecs[2] = '{0, 8'h5A, 8'h02, 0, 8'h00, 8'h00, 1'b0, 16'd2, 8'd0};
        vecs[3] = '{0, 8'h5A, 8'h01, 2, 8'h5A, 8'h6D, 1'b0, 16'd3, 8'd0};
        vecs[4] = '{2, 8'h5A, 8'h02, 0, 8'h00, 8'h00, 1'b1, 16'd3, 8'd0};
        vecs[5] = '{0, 8'hA5, 8'h01, 2, 8'hFF, 8'h37, 1'b1, 16'd4, 8'd0};
        vecs[6] = '{0, 8'hA5, 8'h02, 0, 8'h00, 8'h00, 1'b0, 16'd4, 8'd0};
        vecs[7] = '{0, 8'hA5, 8'h01, 2, 8'hA5, 8'h92, 1'b0, 16'd5, 8'd0};
        vecs[8] = '{0, 8'hA5, 8'h7E, 0, 8'h00, 8'h00, 1'b0, 16'd5, 8'd1};
        vecs[9] = '{0, 8'h00, 8'h01, 2, 8'h00, 8'h37, 1'b0, 16'd6, 8'd1};

        reset = 1'b1; rdy = 1'b0; tx_busy = 1'b0; sensor_valid = 1'b0; alarm_in = 1'b0;
        rxdata = 8'd0; sensor_data = 8'd0;
        tick(2);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_wr_en", {31'd0, wr_en}, 32'd0);
        check("reset_rdy_clr", {31'd0, rdy_clr}, 32'd0);
        check("reset_txdata", {24'd0, txdata}, 32'd0);
        check("reset_counts", {8'd0, req_count, err_count}, 32'd0);
        check("reset_alarm", {31'd0, alarm_pending}, 32'd0);
        reset = 1'b0;
        tick(2);

        for (int v = 0; v < 10; v++) begin
            txq.delete(); wr_cyc.delete(); clr_cnt = 0;
            load_sample(vecs[v].sensor);
            if (vecs[v].mode == 1) begin
                alarm_in = 1'b1; tick(); alarm_in = 1'b0;
            end
            if (vecs[v].mode == 2) alarm_in = 1'b1;
            send(vecs[v].cmd);
            wait_idle(100);
            alarm_in = 1'b0;
            tick(2);
            check($sformatf("v%0d_nbytes", v), txq.size(), vecs[v].n);
            if (vecs[v].n == 2 && txq.size() == 2) begin
                check($sformatf("v%0d_data", v), {24'd0, txq[0]}, {24'd0, vecs[v].b0});
                check($sformatf("v%0d_chk", v), {24'd0, txq[1]}, {24'd0, vecs[v].b1});
                check($sformatf("v%0d_first_wr_latency", v), wr_cyc[0] - clr_cyc, 32'd2);
                check($sformatf("v%0d_wr_spacing", v), wr_cyc[1] - wr_cyc[0], 32'd4);
            end
            check($sformatf("v%0d_rdy_clr_pulses", v), clr_cnt, 32'd1);
            check($sformatf("v%0d_alarm_pending", v), {31'd0, alarm_pending}, {31'd0, vecs[v].ap});
            check($sformatf("v%0d_req_count", v), {16'd0, req_count}, {16'd0, vecs[v].req});
            check($sformatf("v%0d_err_count", v), {24'd0, err_count}, {24'd0, vecs[v].err});
        end

        // Unknown-command saturation: 256 copies of 0x7E in total.
        txq.delete();
        for (int i = 0; i < 253; i++) begin
            send(8'h7E);
            wait_idle(20);
        end
        check("err_count_fe", {24'd0, err_count}, 32'hFE);
        for (int i = 0; i < 2; i++) begin
            send(8'h7E);
            wait_idle(20);
        end
        check("err_count_saturated", {24'd0, err_count}, 32'hFF);
        check("unknown_no_tx", txq.size(), 32'd0);

        // Backpressure plus a second request queued mid-response.
        txq.delete(); wr_cyc.delete(); clr_cnt = 0;
        load_sample(8'h3C);
        tx_busy = 1'b1;
        send(8'h01);
        rdy = 1'b1; rxdata = 8'h01;
        tick(5);
        load_sample(8'hC3);
        tick(14);
        check("stall_no_wr_en", txq.size(), 32'd0);
        check("stall_rdy_clr_once", clr_cnt, 32'd1);
        tx_busy = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 50; i++) begin
                tick();
                if (rdy_clr) begin
                    seen = 1'b1;
                    break;
                end
            end
            rdy = 1'b0;
            if (!seen) check("second_rdy_clr_timeout", 32'd0, 32'd1);
        end
        check("bp_bytes_before_second_ack", txq.size(), 32'd2);
        check("bp_req_before_second", {16'd0, req_count}, 32'd7);
        if (txq.size() >= 2) begin
            check("bp_data", {24'd0, txq[0]}, 32'h3C);
            check("bp_chk", {24'd0, txq[1]}, 32'h0B);
        end
        wait_idle(100);
        tick(2);
        check("bp_total_bytes", txq.size(), 32'd4);
        if (txq.size() == 4) begin
            check("bp2_data", {24'd0, txq[2]}, 32'hC3);
            check("bp2_chk", {24'd0, txq[3]}, 32'hF4);
        end
        check("bp_req_final", {16'd0, req_count}, 32'd8);

        // Reset while waiting in GUARD_DATA.
        txq.delete(); wr_cyc.delete();
        load_sample(8'h11);
        send(8'h01);
        for (int i = 0; i < 20 && txq.size() == 0; i++) tick();
        check("pre_reset_data_sent", txq.size(), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_reset_busy", {31'd0, busy}, 32'd0);
        check("mid_reset_wr_en", {31'd0, wr_en}, 32'd0);
        check("mid_reset_rdy_clr", {31'd0, rdy_clr}, 32'd0);
        check("mid_reset_txdata", {24'd0, txdata}, 32'd0);
        check("mid_reset_counts", {8'd0, req_count, err_count}, 32'd0);
        check("mid_reset_alarm", {31'd0, alarm_pending}, 32'd0);
        tick(3);
        reset = 1'b0;
        tick(10);
        check("no_chk_after_reset", txq.size(), 32'd1);
        load_sample(8'h22);
        send(8'h01);
        wait_idle(100);
        tick(2);
        check("post_reset_nbytes", txq.size(), 32'd3);
        if (txq.size() == 3) begin
            check("post_reset_data", {24'd0, txq[1]}, 32'h22);
            check("post_reset_chk", {24'd0, txq[2]}, 32'h15);
        end
        check("post_reset_req", {16'd0, req_count}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
